// File: rtl/mixer_tune_ctrl.sv
// rtl/mixer_tune_ctrl.sv - NCO phase-increment sequencer with retune mute and frequency sweep
//
// Purpose: owns the NCO phase increment. A single retune or each sweep point loads a
// new word and mutes the mixer for SETTLE_CYC cycles (load cycle included) so the
// downstream filters never see the NCO transient.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   tune_valid/tune_ready      single-retune handshake, tune_word captured on it
//   sweep_start                start pulse, sweep_first/last/step/dwell captured with it
//   abort                      cancel any active operation, phase_inc holds
//   phase_inc, phase_inc_load  NCO word and its one-cycle change strobe
//   mixer_mute, busy           settle-window mute, not-idle flag
//   sweep_done                 one-cycle pulse when a sweep finishes normally
module mixer_tune_ctrl #(
  parameter int                 PHASE_W    = 64,
  parameter int                 SETTLE_CYC = 4,
  parameter int                 DWELL_W    = 16,
  parameter logic [PHASE_W-1:0] RESET_INC  = '0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tune_valid,
  output logic               tune_ready,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic               sweep_start,
  input  logic [PHASE_W-1:0] sweep_first,
  input  logic [PHASE_W-1:0] sweep_last,
  input  logic [PHASE_W-1:0] sweep_step,
  input  logic [DWELL_W-1:0] sweep_dwell,
  input  logic               abort,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               phase_inc_load,
  output logic               mixer_mute,
  output logic               busy,
  output logic               sweep_done
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  // STEP is never occupied: the next-point decision is made on the last dwell
  // cycle and the FSM moves straight into LOAD with the new word.
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, DWELL, STEP} state_e;

  state_e             state_q;
  logic               mode_sweep_q;
  logic [CNT_W-1:0]   settle_cnt_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [PHASE_W-1:0] last_q;
  logic [PHASE_W-1:0] step_q;
  logic [PHASE_W-1:0] phase_inc_q;
  logic               load_q;
  logic               mute_q;
  logic               busy_q;
  logic               ready_q;
  logic               done_q;

  // One extra bit so a step past the top of the word range is seen as the end.
  logic [PHASE_W:0]   sum_d;
  logic               sweep_end_d;
  logic               settle_exp_d;

  assign sum_d        = {1'b0, phase_inc_q} + {1'b0, step_q};
  assign sweep_end_d  = sum_d[PHASE_W] || (sum_d > {1'b0, last_q}) || (step_q == '0);
  assign settle_exp_d = ((state_q == LOAD) && (SETTLE_CYC == 1)) ||
                        ((state_q == SETTLE) && (settle_cnt_q == CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      mode_sweep_q <= 1'b0;
      settle_cnt_q <= '0;
      dwell_cnt_q  <= '0;
      dwell_q      <= '0;
      last_q       <= '0;
      step_q       <= '0;
      phase_inc_q  <= RESET_INC;
      load_q       <= 1'b0;
      mute_q       <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // tune_valid has priority; a simultaneous sweep_start is dropped.
          if (tune_valid || sweep_start) begin
            phase_inc_q  <= tune_valid ? tune_word : sweep_first;
            mode_sweep_q <= !tune_valid;
            if (!tune_valid) begin
              last_q  <= sweep_last;
              step_q  <= sweep_step;
              dwell_q <= (sweep_dwell == '0) ? DWELL_W'(1) : sweep_dwell;
            end
            state_q <= LOAD;
            load_q  <= 1'b1;
            mute_q  <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        LOAD, SETTLE: begin
          if (abort || (settle_exp_d && !mode_sweep_q)) begin
            state_q <= IDLE;
            mute_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (settle_exp_d) begin
            state_q     <= DWELL;
            mute_q      <= 1'b0;
            dwell_cnt_q <= dwell_q;
          end else if (state_q == LOAD) begin
            state_q      <= SETTLE;
            settle_cnt_q <= CNT_W'(SETTLE_CYC - 1);
          end else begin
            settle_cnt_q <= settle_cnt_q - CNT_W'(1);
          end
        end
        DWELL: begin
          if (abort || ((dwell_cnt_q == DWELL_W'(1)) && sweep_end_d)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= !abort;
          end else if (dwell_cnt_q == DWELL_W'(1)) begin
            phase_inc_q <= sum_d[PHASE_W-1:0];
            state_q     <= LOAD;
            load_q      <= 1'b1;
            mute_q      <= 1'b1;
          end else begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          mute_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign phase_inc      = phase_inc_q;
  assign phase_inc_load = load_q;
  assign mixer_mute     = mute_q;
  assign busy           = busy_q;
  assign tune_ready     = ready_q;
  assign sweep_done     = done_q;

endmodule

// File: doc/mixer_tune_ctrl.md
Name: mixer_tune_ctrl

Overview:
Sequencing controller for the NCO/mixer front end. It owns the NCO phase-increment register feeding the sin/cos generator that drives the 1-bit-RF mixer. It supports single glitch-free retunes and automatic frequency sweeps. On every frequency change it asserts mixer_mute for a fixed settle window, so downstream filters never integrate the NCO transient.

Parameters:
PHASE_W, 64, width of NCO phase increment and all tuning words
SETTLE_CYC, 4, mute cycles per retune, including the load cycle (legal range >= 1)
DWELL_W, 16, width of dwell counter/input
RESET_INC, 0, phase_inc value after reset

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
tune_valid  in  1  single-retune request
tune_ready  out  1  high only in IDLE; handshake = tune_valid & tune_ready
tune_word  in  PHASE_W  requested phase increment, captured on handshake
sweep_start  in  1  start-sweep pulse, sampled only in IDLE
sweep_first  in  PHASE_W  sweep start word
sweep_last  in  PHASE_W  sweep stop word (unsigned, inclusive)
sweep_step  in  PHASE_W  increment between points
sweep_dwell  in  DWELL_W  unmuted cycles per point (0 treated as 1)
abort  in  1  cancel any active operation
phase_inc  out  PHASE_W  to NCO
phase_inc_load  out  1  one-cycle strobe, phase_inc changed this cycle
mixer_mute  out  1  high while NCO settling
busy  out  1  state != IDLE
sweep_done  out  1  one-cycle pulse on normal sweep completion

Behaviour:
- Reset (rstn=0 at clock edge):
  - phase_inc=RESET_INC; phase_inc_load=0, mixer_mute=0, busy=0, sweep_done=0, tune_ready=1.
  - State=IDLE. All requests are ignored while reset is held.
  - Reset mid-operation aborts immediately; no done pulse is issued.
- States: IDLE, LOAD, SETTLE, DWELL, STEP.
- IDLE:
  - tune_valid → latch tune_word, set mode=SINGLE, go to LOAD.
  - sweep_start with no tune_valid → latch first/last/step/dwell, set mode=SWEEP, go to LOAD.
  - If tune_valid and sweep_start arrive together, tune_valid wins and sweep_start is dropped.
  - While not IDLE, tune_valid and sweep_start are ignored; no queuing.
- LOAD (1 cycle, the handshake cycle is cycle 0, so LOAD is cycle 1):
  - phase_inc updates to the target word; phase_inc_load=1; mixer_mute=1.
  - Settle counter loads SETTLE_CYC-1; go to SETTLE, or straight to the post-settle state if SETTLE_CYC=1.
- SETTLE:
  - mixer_mute=1; counter decrements each cycle.
  - Mute is high for exactly SETTLE_CYC cycles counting the LOAD cycle.
  - When the count expires: SINGLE mode goes to IDLE (tune_ready=1 on cycle SETTLE_CYC+1); SWEEP mode goes to DWELL.
- DWELL:
  - mixer_mute=0 for max(sweep_dwell,1) cycles.
  - On the last dwell cycle, compute sum = {0,phase_inc}+{0,step} at PHASE_W+1 bits.
  - If sum[PHASE_W]=1, or sum > last, or step=0: the next cycle is IDLE with sweep_done=1 for that cycle (tune_ready also 1), and phase_inc holds the final point.
  - Otherwise go to STEP.
- STEP: 0-cycle decision folded into LOAD. The next cycle is LOAD with target=sum.
- Sweep timing:
  - Point spacing between phase_inc_load strobes = SETTLE_CYC + dwell.
  - If first > last, exactly one point (first) is played, then done.
- abort:
  - In any non-IDLE state, the next cycle is IDLE: mixer_mute=0, busy=0, phase_inc holds its current value, no sweep_done.
  - In IDLE, abort has no effect.
  - If abort coincides with the last dwell cycle, abort wins and there is no done pulse.
- Output registration:
  - All outputs are registered.
  - phase_inc changes only in cycles where phase_inc_load=1.
  - mixer_mute changes only on state transitions.

Test Plan:
1. Hold rstn=0 for 3 cycles with tune_valid=1, sweep_start=1 → phase_inc=0, load=0, mute=0, busy=0, ready=1 throughout and on the first cycle after release.
2. Handshake tune_word=0x1000 at cycle 0 → cycle 1: phase_inc=0x1000, load=1 for 1 cycle; mute=1 for cycles 1–4; ready=1 at cycle 5. A second tune_valid at cycle 2 is ignored.
3. Sweep first=100, last=130, step=10, dwell=3 → load strobes at cycles 1, 8, 15, 22 with values 100, 110, 120, 130; mute low for cycles 5–7, 12–14, etc.; sweep_done at cycle 29; phase_inc stays 130.
4. Sweep first=2^64−16, step=32, last=2^64−1 → single load (2^64−16), no wrap, done after 4+dwell cycles. Repeat with step=0 and with first=200, last=100 → each plays one point, then done.
5. Sweep as in test 3; abort at cycle 10 → cycle 11: IDLE, mute=0, busy=0, phase_inc=110, no sweep_done. Abort on the final dwell cycle → no done pulse.
6. tune_valid and sweep_start in the same IDLE cycle, tune_word=0x55, sweep_first=0x99 → single retune to 0x55 only, no DWELL, no sweep_done.
